// File: rtl/fpadd_pkg.sv
// Shared definitions for the FP8 adder issue path.
// Holds FP8 field layout, operand-pair bundle and issue FSM states.
package fpadd_pkg;

    localparam int SIGN_BIT = 7;
    localparam int EXP_MSB  = 6;
    localparam int EXP_LSB  = 4;
    localparam int MAN_MSB  = 3;
    localparam int MAN_LSB  = 0;
    localparam int FP_W     = SIGN_BIT + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        START,
        WAIT
    } issue_state_t;

    typedef struct packed {
        logic                       sign;
        logic [EXP_MSB-EXP_LSB:0]   exp;
        logic [MAN_MSB-MAN_LSB:0]   man;
    } fp8_t;

    typedef struct packed {
        fp8_t a;
        fp8_t b;
    } opnd_pair_t;

endpackage

// File: rtl/fpadd_opfifo.sv
// Operand-pair FIFO feeding the adder issue FSM.
// Flush clears pointers and count and wins over a same-cycle push.
module fpadd_opfifo
    import fpadd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  opnd_pair_t    wdata,
    output opnd_pair_t    rdata,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    opnd_pair_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign count = cnt_q;

endmodule

// File: rtl/fpadd_issue.sv
// Issue stage in front of the FP8 adder: queues operand pairs and
// sequences LOAD/START/WAIT with a fixed latency since the adder has no done.
module fpadd_issue
    import fpadd_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int ADD_LATENCY = 8
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         in_valid,
    input  logic [FP_W-1:0]              in_a,
    input  logic [FP_W-1:0]              in_b,
    output logic                         in_ready,
    input  logic                         flush,
    output logic [FP_W-1:0]              a,
    output logic [FP_W-1:0]              b,
    output logic                         start,
    output logic                         busy,
    output logic                         op_done,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int LW = $clog2(ADD_LATENCY + 1);

    issue_state_t  state;
    issue_state_t  next_state;
    logic [LW-1:0] cnt_q;
    logic [LW-1:0] cnt_d;
    logic          push;
    logic          pop;
    logic          have_pair;
    logic          start_d;
    logic          op_done_d;
    logic          start_q;
    logic          op_done_q;
    logic [FP_W-1:0] a_q;
    logic [FP_W-1:0] b_q;
    opnd_pair_t    head;
    logic [CW-1:0] fifo_count;

    assign in_ready  = (fifo_count != CW'(DEPTH));
    assign push      = in_valid && in_ready && !flush;
    // A flush this cycle empties the queue, so nothing is available to pop.
    assign have_pair = (fifo_count != '0) && !flush;

    fpadd_opfifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_opfifo (
        .clk   (clk),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (opnd_pair_t'({in_a, in_b})),
        .rdata (head),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (have_pair) next_state = LOAD;
            LOAD:    next_state = START;
            START:   next_state = WAIT;
            WAIT:    if (cnt_q == '0)
                         next_state = have_pair ? LOAD : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        pop   = (next_state == LOAD);
        cnt_d = cnt_q;
        unique case (1'b1)
            (state == START):
                cnt_d = LW'(ADD_LATENCY - 1);
            (state == WAIT && cnt_q != '0):
                cnt_d = cnt_q - LW'(1);
            default:
                cnt_d = cnt_q;
        endcase
        start_d   = (next_state == START);
        op_done_d = (next_state == WAIT) && (cnt_d == '0);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q     <= '0;
            start_q   <= 1'b0;
            op_done_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            cnt_q     <= cnt_d;
            start_q   <= start_d;
            op_done_q <= op_done_d;
            if (pop) begin
                a_q <= head.a;
                b_q <= head.b;
            end
        end
    end

    assign a       = a_q;
    assign b       = b_q;
    assign start   = start_q;
    assign op_done = op_done_q;
    assign busy    = (state != IDLE);
    assign count   = fifo_count;

endmodule

// File: tb/tb_fpadd_issue.sv
// Directed bench for fpadd_issue with DEPTH=4, ADD_LATENCY=8.
// Cycle k starts 1 ns after a rising edge; inputs and checks both happen there.
module tb_fpadd_issue;

    logic       clk = 1'b0;
    logic       clr;
    logic       in_valid;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_ready;
    logic       flush;
    logic [7:0] a;
    logic [7:0] b;
    logic       start;
    logic       busy;
    logic       op_done;
    logic [2:0] count;

    int total = 0;
    int bad   = 0;

    logic [7:0] pa [6] = '{8'h34, 8'h11, 8'hA5, 8'h47, 8'hC3, 8'h5E};
    logic [7:0] pb [6] = '{8'h2C, 8'h22, 8'h96, 8'h78, 8'h0F, 8'hE1};

    always #5 clk = ~clk;

    fpadd_issue #(
        .DEPTH       (4),
        .ADD_LATENCY (8)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .in_valid (in_valid),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_ready (in_ready),
        .flush    (flush),
        .a        (a),
        .b        (b),
        .start    (start),
        .busy     (busy),
        .op_done  (op_done),
        .count    (count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int sent;
        clr      = 1'b1;
        in_valid = 1'b0;
        in_a     = 8'h00;
        in_b     = 8'h00;
        flush    = 1'b0;

        // reset state, with a push offered while in reset
        tick;
        in_valid = 1'b1;
        in_a     = 8'hFF;
        in_b     = 8'hFF;
        tick;
        chk("rst a", a, 16'h00);
        chk("rst b", b, 16'h00);
        chk("rst start", start, 16'd0);
        chk("rst op_done", op_done, 16'd0);
        chk("rst busy", busy, 16'd0);
        chk("rst count", count, 16'd0);
        chk("rst in_ready", in_ready, 16'd1);
        in_valid = 1'b0;
        clr      = 1'b0;
        tick;
        chk("post-rst count", count, 16'd0);

        // single operation
        tick;
        in_valid = 1'b1;
        in_a     = 8'h34;
        in_b     = 8'h2C;
        for (int k = 1; k <= 13; k++) begin
            tick;
            in_valid = 1'b0;
            chk($sformatf("t2 start c%0d", k), start, 16'(k == 3));
            chk($sformatf("t2 op_done c%0d", k), op_done, 16'(k == 11));
            chk($sformatf("t2 busy c%0d", k), busy, 16'(k >= 2 && k <= 11));
            if (k == 1)
                chk("t2 count c1", count, 16'd1);
            if (k >= 2) begin
                chk($sformatf("t2 a c%0d", k), a, 16'h34);
                chk($sformatf("t2 b c%0d", k), b, 16'h2C);
            end
        end

        // back-to-back three pairs
        for (int k = 0; k <= 33; k++) begin
            tick;
            in_valid = (k < 3);
            if (k < 3) begin
                in_a = pa[k];
                in_b = pb[k];
            end
            chk($sformatf("t3 start c%0d", k), start,
                16'(k == 3 || k == 13 || k == 23));
            chk($sformatf("t3 op_done c%0d", k), op_done,
                16'(k == 11 || k == 21 || k == 31));
            if (k == 3 || k == 13 || k == 23) begin
                chk($sformatf("t3 a c%0d", k), a, 16'(pa[(k - 3) / 10]));
                chk($sformatf("t3 b c%0d", k), b, 16'(pb[(k - 3) / 10]));
            end
            if (k == 32)
                chk("t3 busy c32", busy, 16'd0);
        end
        in_valid = 1'b0;

        // full FIFO backpressure and ordering
        sent = 0;
        for (int k = 0; k <= 62; k++) begin
            tick;
            if (k <= 12)
                chk($sformatf("t4 in_ready c%0d", k), in_ready,
                    16'(!(k >= 5 && k <= 11)));
            if (k == 5)
                chk("t4 count c5", count, 16'd4);
            if (k == 12)
                chk("t4 sent c12", 16'(sent), 16'd5);
            in_valid = (sent < 6);
            if (sent < 6) begin
                in_a = pa[sent];
                in_b = pb[sent];
            end
            if (in_valid && in_ready)
                sent++;
            chk($sformatf("t4 start c%0d", k), start,
                16'(k >= 3 && k <= 53 && (k - 3) % 10 == 0));
            if (k >= 3 && k <= 53 && (k - 3) % 10 == 0) begin
                chk($sformatf("t4 a c%0d", k), a, 16'(pa[(k - 3) / 10]));
                chk($sformatf("t4 b c%0d", k), b, 16'(pb[(k - 3) / 10]));
            end
            if (k == 61)
                chk("t4 op_done c61", op_done, 16'd1);
            if (k == 62)
                chk("t4 busy c62", busy, 16'd0);
        end
        in_valid = 1'b0;
        chk("t4 sent total", 16'(sent), 16'd6);

        // flush while waiting on an in-flight op
        for (int k = 0; k <= 25; k++) begin
            tick;
            in_valid = (k < 4);
            if (k < 4) begin
                in_a = pa[k];
                in_b = pb[k];
            end
            flush = (k == 5);
            if (k == 4)
                chk("t5 count c4", count, 16'd3);
            if (k == 5)
                chk("t5 busy c5", busy, 16'd1);
            if (k == 6)
                chk("t5 count c6", count, 16'd0);
            chk($sformatf("t5 start c%0d", k), start, 16'(k == 3));
            chk($sformatf("t5 op_done c%0d", k), op_done, 16'(k == 11));
            if (k >= 2)
                chk($sformatf("t5 a c%0d", k), a, 16'(pa[0]));
        end
        flush    = 1'b0;
        in_valid = 1'b0;

        // flush and push in the same cycle
        tick;
        in_valid = 1'b1;
        flush    = 1'b1;
        in_a     = pa[5];
        in_b     = pb[5];
        for (int k = 1; k <= 5; k++) begin
            tick;
            in_valid = 1'b0;
            flush    = 1'b0;
            chk($sformatf("t6 count c%0d", k), count, 16'd0);
            chk($sformatf("t6 in_ready c%0d", k), in_ready, 16'd1);
            chk($sformatf("t6 start c%0d", k), start, 16'd0);
            chk($sformatf("t6 busy c%0d", k), busy, 16'd0);
        end

        // reset in WAIT with two pairs queued
        for (int k = 0; k <= 25; k++) begin
            tick;
            in_valid = (k < 3);
            if (k < 3) begin
                in_a = pa[k + 3];
                in_b = pb[k + 3];
            end
            if (k == 6) begin
                chk("t1 busy pre", busy, 16'd1);
                chk("t1 count pre", count, 16'd2);
                chk("t1 a pre", a, 16'(pa[3]));
                clr = 1'b1;
            end
            if (k == 7) begin
                chk("t1 a", a, 16'h00);
                chk("t1 b", b, 16'h00);
                chk("t1 start", start, 16'd0);
                chk("t1 op_done", op_done, 16'd0);
                chk("t1 busy", busy, 16'd0);
                chk("t1 count", count, 16'd0);
            end
            if (k == 8)
                clr = 1'b0;
            if (k >= 8) begin
                chk($sformatf("t1 start c%0d", k), start, 16'd0);
                chk($sformatf("t1 op_done c%0d", k), op_done, 16'd0);
                chk($sformatf("t1 busy c%0d", k), busy, 16'd0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
